serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial add/subtract controller that time-shares a single 1-bit full-adder cell across a WIDTH-bit operation, LSB first. It latches the operands on a start handshake, steps the cell once per clock while holding the carry in a register, and returns the WIDTH-bit result with carry-out and signed overflow. It sits between a requester issuing occasional wide adds and the area-minimal full-adder datapath.

## Interface
- WIDTH, 8: operand/result width in bits. Legal values are 2..32.
- clk  in  1  single clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only in IDLE.
- sub  in  1  0 = A+B+cin, 1 = A−B (computed as A+~B+1, cin ignored).
- cin  in  1  carry-in for add mode.
- a  in  WIDTH  operand A, sampled at accept.
- b  in  WIDTH  operand B, sampled at accept.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; the result is valid from this cycle on.
- sum  out  WIDTH  result; held until the next accept.
- cout  out  1  final carry (in subtract mode, 1 = no borrow).
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- States are IDLE, RUN and DONE.
- IDLE: if start = 1, then on the next edge:
  - a_sh ← a;
  - b_sh ← (sub ? ~b : b);
  - carry ← (sub ? 1 : cin);
  - bit counter ← 0;
  - go to RUN.
- RUN: each cycle, the full-adder cell takes a_sh[0], b_sh[0] and carry.
  - On the edge, the cell's s shifts into the MSB of the sum shift register (sum_sh ← {s, sum_sh[WIDTH-1:1]}).
  - a_sh and b_sh shift right; carry ← cell cout; the counter increments.
  - When counter = WIDTH−1, also capture ovf ← carry_in_this_cycle ^ cell cout and go to DONE.
- DONE: lasts one cycle. done = 1, sum = sum_sh, cout = carry. Next state is IDLE.
- sum, cout and ovf hold their values in IDLE until the next accept. The sum shift register is not cleared at accept, so it is overwritten bit by bit. sum is driven from a separate output register loaded on entry to DONE, so sum never shows partial results.
- start while busy = 1 is ignored; it is not queued.
- start in the DONE cycle is ignored. A new request is accepted in the following IDLE cycle.
- Asynchronous reset in any state: state → IDLE. busy, done, sum, cout, ovf, carry and the counter all → 0. Any in-flight operation is discarded and no done is produced.

## Timing
- Accept edge at T (start sampled high in IDLE). RUN occupies cycles T+1 … T+WIDTH. done is high in cycle T+WIDTH+1.
- Latency from the start edge to done is WIDTH+1 cycles.
- Minimum spacing between accepts is WIDTH+2 cycles. Throughput is one result per WIDTH+2 cycles under back-to-back start.
- busy rises in the cycle after the accept edge. It falls in the cycle after done.
- Reset values: busy = 0, done = 0, sum = 0, cout = 0, ovf = 0.
- The counter is sized as $clog2(WIDTH); it never wraps because the exit condition is WIDTH−1.

## Structure
- The package serial_add_pkg holds:
  - the state enum (IDLE, RUN, DONE), 2 bits;
  - the mode constants MODE_ADD = 0 and MODE_SUB = 1.
- One sub-module, fa_cell: a combinational 1-bit full adder with ports a, b, cin, s, cout, where s = a^b^cin and cout = ab | (a^b)cin. It is instantiated once; the controller contains no other adder logic.

## Test plan
- WIDTH = 8, add: a = 0x35, b = 0x4A, cin = 0, start for 1 cycle → done exactly 9 cycles after the accept edge, sum = 0x7F, cout = 0, ovf = 0.
- Add, carry and overflow: a = 0x7F, b = 0x01, cin = 0 → sum = 0x80, cout = 0, ovf = 1. Then a = 0xFF, b = 0x01, cin = 1 → sum = 0x01, cout = 1, ovf = 0.
- Subtract: sub = 1, a = 0x10, b = 0x20, cin = 1 (ignored) → sum = 0xF0, cout = 0 (borrow), ovf = 0. Then a = 0x80, b = 0x01 → sum = 0x7F, cout = 1, ovf = 1.
- Handshake: hold start high continuously with new operands each cycle → accepts occur every 10 cycles. Operands presented while busy are not used, and done pulses exactly once per accept.
- Reset mid-operation: assert rst_n = 0 during RUN at bit 4 → all outputs go to 0 immediately without a clock edge, and no done follows. After release, a new add of 0x01 + 0x01 gives sum = 0x02.
- Result hold: after done, with start low for 20 cycles, sum, cout and ovf stay stable and busy = 0 throughout.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Combinational 1-bit full adder; the only adder in the controller.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and carry of a single bit position
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | ((a ^ b) & cin);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell stepped LSB first.
//
// state | meaning
// IDLE  | waiting for start; last result held on sum/cout/ovf
// RUN   | one operand bit per cycle through the shared cell
// DONE  | single-cycle done pulse, result already on the outputs
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_sh_nxt;
  logic             carry;
  logic [CNT_W-1:0] bit_cnt;
  logic             last_bit;
  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  fa_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

  // Next sum shift value: cell output enters at the MSB
  always_comb begin
    sum_sh_nxt            = sum_sh >> 1;
    sum_sh_nxt[WIDTH-1]   = fa_s;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start outside IDLE is dropped, not queued
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Operand/carry/counter datapath and result registers loaded on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry   <= 1'b0;
      bit_cnt <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        a_sh    <= a;
        b_sh    <= (sub == MODE_SUB) ? ~b : b;
        carry   <= (sub == MODE_ADD) ? cin : 1'b1;
        bit_cnt <= '0;
      end else if (state == RUN) begin
        a_sh    <= a_sh >> 1;
        b_sh    <= b_sh >> 1;
        sum_sh  <= sum_sh_nxt;
        carry   <= fa_cout;
        bit_cnt <= bit_cnt + 1'b1;
        if (last_bit) begin
          sum_q  <= sum_sh_nxt;
          cout_q <= fa_cout;
          ovf_q  <= carry ^ fa_cout;
        end
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH = 8.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vsub;
    logic       vcin;
    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[8];

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request; returns edges from accept edge (counted as 1) to done.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                        input logic tc, output int lat, output logic got_done);
    @(negedge clk);
    a = ta; b = tb_v; sub = ts; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    got_done = 1'b0;
    @(negedge clk);
    start = 1'b0;
    a = ~ta; b = ~tb_v; cin = ~tc;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int         lat;
    logic       ok;
    logic [7:0] pa, pb;
    logic [7:0] exp_q[$];
    logic       prev_busy, prev_done;
    int         accepts, dones, last_acc;
    logic [7:0] exp_s;

    vecs[0] = '{8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[3] = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{8'h05, 8'h05, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven add/subtract vectors
    for (int v = 0; v < 8; v++) begin
      run_op(vecs[v].va, vecs[v].vb, vecs[v].vsub, vecs[v].vcin, lat, ok);
      check($sformatf("v%0d_done_seen", v), 32'(ok), 32'd1);
      check($sformatf("v%0d_latency", v), 32'(lat), 32'd9);
      check($sformatf("v%0d_sum", v), 32'(sum), 32'(vecs[v].exp_sum));
      check($sformatf("v%0d_cout", v), 32'(cout), 32'(vecs[v].exp_cout));
      check($sformatf("v%0d_ovf", v), 32'(ovf), 32'(vecs[v].exp_ovf));
      check($sformatf("v%0d_busy_in_done", v), 32'(busy), 32'd1);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_fall", v), 32'(done), 32'd0);
      check($sformatf("v%0d_busy_fall", v), 32'(busy), 32'd0);
    end

    // Back-to-back: start held high, fresh operands every cycle
    @(negedge clk);
    sub = 1'b0; cin = 1'b0; start = 1'b1;
    a = 8'($urandom); b = 8'($urandom); pa = a; pb = b;
    prev_busy = 1'b0; prev_done = 1'b0;
    accepts = 0; dones = 0; last_acc = -1;
    for (int cyc = 0; cyc < 56; cyc++) begin
      @(posedge clk); #1;
      if (busy && !prev_busy) begin
        accepts++;
        if (last_acc >= 0) check("accept_spacing", 32'(cyc - last_acc), 32'd10);
        last_acc = cyc;
        exp_q.push_back(8'(pa + pb));
      end
      if (done) begin
        dones++;
        check("done_single_cycle", 32'(prev_done), 32'd0);
        if (exp_q.size() > 0) begin
          exp_s = exp_q.pop_front();
          check("b2b_sum", 32'(sum), 32'(exp_s));
        end else begin
          check("b2b_done_without_accept", 32'd1, 32'd0);
        end
      end
      prev_busy = busy;
      prev_done = done;
      @(negedge clk);
      if (cyc >= 40) start = 1'b0;
      else begin
        a = 8'($urandom); b = 8'($urandom); pa = a; pb = b;
      end
    end
    check("b2b_accepts", 32'(accepts), 32'd5);
    check("b2b_dones", 32'(dones), 32'd5);

    // Result hold with start low
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, lat, ok);
    check("hold_done_seen", 32'(ok), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("hold_sum", 32'(sum), 32'h80);
      check("hold_cout", 32'(cout), 32'd0);
      check("hold_ovf", 32'(ovf), 32'd1);
      check("hold_busy", 32'(busy), 32'd0);
    end

    // Reset during RUN at bit 4
    @(negedge clk);
    a = 8'h55; b = 8'h0F; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    run_op(8'h01, 8'h01, 1'b0, 1'b0, lat, ok);
    check("post_rst_done_seen", 32'(ok), 32'd1);
    check("post_rst_sum", 32'(sum), 32'h02);
    check("post_rst_cout", 32'(cout), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
